// File: rtl/sample_feeder.sv
// Purpose : buffers samples in a small FIFO and offers them one at a time on a data_ready/modwait handshake.
// Latency : a write into an empty FIFO at edge N shows data_ready=1 after edge N+1 (if modwait is low).
// Backpres: writes while full are dropped with a one-cycle overrun pulse; an unacknowledged sample is dropped after TIMEOUT cycles.
//
// Ports:
//   clk, n_reset           - clock (rising edge), asynchronous active-low reset
//   wr_en, wr_data         - sample enqueue side
//   full, empty, overrun   - FIFO status (full/empty decode from occupancy; overrun registered)
//   modwait, err           - controller acknowledge/busy and error flag
//   data_ready, sample     - sample offered to the controller
//   timeout                - pulse: offered sample dropped without acknowledge
//   sample_count           - acknowledged samples, wraps
//   err_count              - rising edges of err, saturates at 255
module sample_feeder #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic              overrun,
  input  logic              modwait,
  input  logic              err,
  output logic              data_ready,
  output logic [DATA_W-1:0] sample,
  output logic              timeout,
  output logic [7:0]        sample_count,
  output logic [7:0]        err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, PRESENT, WAIT_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [CW-1:0]     r_wait_cnt;
  logic              r_err_d;
  logic              r_data_ready;
  logic [DATA_W-1:0] r_sample;
  logic              r_overrun;
  logic              r_timeout;
  logic [7:0]        r_sample_count;
  logic [7:0]        r_err_count;

  logic              w_push;
  logic              w_pop;
  logic              w_ack;
  logic              w_to;

  assign full         = (r_count == FULL_CNT);
  assign empty        = (r_count == '0);
  assign overrun      = r_overrun;
  assign data_ready   = r_data_ready;
  assign sample       = r_sample;
  assign timeout      = r_timeout;
  assign sample_count = r_sample_count;
  assign err_count    = r_err_count;

  // A full FIFO rejects the write even when a pop happens on the same edge.
  assign w_push = wr_en && !full;

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_ack  = 1'b0;
    w_to   = 1'b0;
    case (r_state)
      IDLE: begin
        // modwait still high means the controller is busy: hold off.
        if (!empty && !modwait) begin
          w_next = PRESENT;
          w_pop  = 1'b1;
        end
      end
      PRESENT: begin
        if (modwait) begin
          w_next = WAIT_DONE;
          w_ack  = 1'b1;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_next = IDLE;
          w_to   = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!modwait) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Storage has no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state        <= IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_wait_cnt     <= '0;
      r_err_d        <= 1'b0;
      r_data_ready   <= 1'b0;
      r_sample       <= '0;
      r_overrun      <= 1'b0;
      r_timeout      <= 1'b0;
      r_sample_count <= '0;
      r_err_count    <= '0;
    end else begin
      r_state <= w_next;

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Counter value is irrelevant outside PRESENT; it is cleared on entry.
      if (w_pop)                   r_wait_cnt <= '0;
      else if (r_state == PRESENT) r_wait_cnt <= r_wait_cnt + 1'b1;

      // sample only changes on a pop, so it stays stable through WAIT_DONE.
      if (w_pop) r_sample <= r_mem[r_rd_ptr];

      r_data_ready <= (w_next == PRESENT);
      r_overrun    <= wr_en && full;
      r_timeout    <= w_to;

      if (w_ack) r_sample_count <= r_sample_count + 1'b1;

      r_err_d <= err;
      if (err && !r_err_d && (r_err_count != 8'hFF))
        r_err_count <= r_err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_sample_feeder.sv
module tb_sample_feeder;

  localparam int DW      = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic          clk;
  logic          n_reset;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          empty;
  logic          overrun;
  logic          modwait;
  logic          err;
  logic          data_ready;
  logic [DW-1:0] sample;
  logic          timeout;
  logic [7:0]    sample_count;
  logic [7:0]    err_count;

  sample_feeder #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .n_reset(n_reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .overrun(overrun), .modwait(modwait), .err(err),
    .data_ready(data_ready), .sample(sample), .timeout(timeout),
    .sample_count(sample_count), .err_count(err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    logic          dr, full, empty, ovr, to, hold;
    logic [7:0]    sc, ec;
    logic [DW-1:0] smp;
  } exp_t;

  exp_t          exp_q [$];   // expected status after each edge
  logic [DW-1:0] pres_q[$];   // expected order of offered samples
  logic [DW-1:0] mq    [$];   // samples the model holds in the FIFO
  int            m_ph   = 0;  // 0 idle, 1 offering, 2 acknowledged
  int            m_wait = 0;
  logic [7:0]    m_sc   = 0;
  logic [7:0]    m_ec   = 0;
  logic          m_prev_er = 0;
  logic [DW-1:0] m_cur  = 0;

  initial forever begin
    @(posedge clk or negedge n_reset);
    if (!n_reset) begin
      mq.delete(); exp_q.delete(); pres_q.delete();
      m_ph = 0; m_wait = 0; m_sc = 0; m_ec = 0; m_prev_er = 0; m_cur = 0;
    end else begin
      automatic exp_t e;
      automatic logic wr = wr_en, mw = modwait, er = err;
      automatic logic [DW-1:0] wd = wr_data;
      automatic logic acc = wr && (mq.size() < DEPTH);
      e.ovr = wr && (mq.size() == DEPTH);
      e.to  = 1'b0;
      if (m_ph == 0) begin
        if (mq.size() > 0 && !mw) begin
          m_cur = mq.pop_front();
          pres_q.push_back(m_cur);
          m_ph = 1; m_wait = 0;
        end
      end else if (m_ph == 1) begin
        if (mw) begin m_ph = 2; m_sc = m_sc + 8'd1; end
        else if (m_wait == TIMEOUT - 1) begin m_ph = 0; e.to = 1'b1; end
        else m_wait++;
      end else begin
        if (!mw) m_ph = 0;
      end
      if (acc) mq.push_back(wd);
      if (er && !m_prev_er && m_ec != 8'd255) m_ec = m_ec + 8'd1;
      m_prev_er = er;
      e.dr = (m_ph == 1); e.hold = (m_ph != 0); e.smp = m_cur;
      e.full = (mq.size() == DEPTH); e.empty = (mq.size() == 0);
      e.sc = m_sc; e.ec = m_ec;
      exp_q.push_back(e);
    end
  end

  // ---------------- monitor ----------------
  logic prev_dr = 1'b0;
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      automatic exp_t e = exp_q.pop_front();
      chk("data_ready", 32'(data_ready), 32'(e.dr));
      chk("full", 32'(full), 32'(e.full));
      chk("empty", 32'(empty), 32'(e.empty));
      chk("overrun", 32'(overrun), 32'(e.ovr));
      chk("timeout", 32'(timeout), 32'(e.to));
      chk("sample_count", 32'(sample_count), 32'(e.sc));
      chk("err_count", 32'(err_count), 32'(e.ec));
      if (e.hold) chk("sample_stable", 32'(sample), 32'(e.smp));
    end
    if (n_reset && data_ready && !prev_dr) begin
      if (pres_q.size() == 0) chk("present_unexpected", 32'(sample), 32'hFFFF_FFFF);
      else chk("present_order", 32'(sample), 32'(pres_q.pop_front()));
    end
    prev_dr = n_reset ? data_ready : 1'b0;
  end

  // ---------------- controller model ----------------
  int ctl_mode = 0;          // 0 modwait tied low, 1 busy (held high), 2 responsive
  int ctl_d = 2, ctl_d_lo = 2, ctl_d_hi = 2;
  int ctl_h = 8, ctl_h_lo = 8, ctl_h_hi = 8;
  initial begin
    automatic int cnt = 0;
    modwait = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ctl_mode == 0) begin modwait = 1'b0; cnt = 0; end
      else if (ctl_mode == 1) begin modwait = 1'b1; cnt = 0; end
      else if (!modwait) begin
        if (data_ready) begin
          cnt++;
          if (cnt >= ctl_d) begin
            modwait = 1'b1; cnt = 0;
            ctl_h = $urandom_range(ctl_h_hi, ctl_h_lo);
          end
        end else cnt = 0;
      end else begin
        ctl_h--;
        if (ctl_h <= 0) begin
          modwait = 1'b0;
          ctl_d = $urandom_range(ctl_d_hi, ctl_d_lo);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write(input logic [DW-1:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    automatic int good = 0;
    for (int i = 0; i < 400 && good < 2; i++) begin
      tick();
      good = (empty && !data_ready && !modwait) ? good + 1 : 0;
    end
    chk(name, 32'(good >= 2), 32'd1);
  endtask

  initial begin
    automatic int n_dr = 0, n_to = 0;
    n_reset = 1'b0; wr_en = 1'b0; wr_data = '0; err = 1'b0;
    repeat (2) tick();
    chk("rst_data_ready", 32'(data_ready), 0);
    chk("rst_sample", 32'(sample), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_sample_count", 32'(sample_count), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_empty", 32'(empty), 1);
    n_reset = 1'b1;
    repeat (2) tick();

    // Single sample: ack 2 cycles after data_ready, held 8 cycles.
    ctl_d_lo = 2; ctl_d_hi = 2; ctl_d = 2; ctl_h_lo = 8; ctl_h_hi = 8; ctl_mode = 2;
    write(16'h1234);
    chk("single_lat_early", 32'(data_ready), 0);
    tick();
    chk("single_lat", 32'(data_ready), 1);
    chk("single_sample", 32'(sample), 32'h1234);
    wait_quiet("single_settle");
    chk("single_count", 32'(sample_count), 1);
    chk("single_empty", 32'(empty), 1);

    // Burst while controller busy, then overrun with DEAD.
    ctl_mode = 1;
    repeat (2) tick();
    for (int i = 1; i <= 4; i++) write(DW'(i));
    chk("burst_full", 32'(full), 1);
    write(16'hDEAD);
    chk("overrun_pulse", 32'(overrun), 1);
    chk("overrun_full", 32'(full), 1);
    tick();
    chk("overrun_clear", 32'(overrun), 0);
    ctl_d_lo = 2; ctl_d_hi = 4; ctl_h_lo = 2; ctl_h_hi = 3; ctl_h = 1; ctl_mode = 2;
    wait_quiet("burst_settle");
    chk("burst_count", 32'(sample_count), 5);

    // Timeout: modwait tied low, two samples both expire.
    ctl_mode = 0;
    repeat (3) tick();
    wr_en = 1'b1; wr_data = 16'hAAAA; tick();
    wr_data = 16'hBBBB; tick();
    wr_en = 1'b0;
    for (int i = 0; i < 30; i++) begin
      n_dr += int'(data_ready);
      n_to += int'(timeout);
      tick();
    end
    chk("to_dr_cycles", 32'(n_dr), 2 * TIMEOUT);
    chk("to_pulses", 32'(n_to), 2);
    chk("to_count", 32'(sample_count), 5);

    // Error edges: three single pulses plus one long hold.
    for (int i = 0; i < 3; i++) begin err = 1'b1; tick(); err = 1'b0; tick(); end
    err = 1'b1; repeat (5) tick(); err = 1'b0; repeat (2) tick();
    chk("err_count4", 32'(err_count), 4);

    // Random traffic, random ack delays (some beyond the timeout), random err.
    ctl_d_lo = 1; ctl_d_hi = TIMEOUT + 2; ctl_h_lo = 1; ctl_h_hi = 4; ctl_d = 3; ctl_mode = 2;
    for (int i = 0; i < 2000; i++) begin
      wr_en = ($urandom_range(2, 0) == 0);
      wr_data = DW'($urandom);
      err = 1'($urandom);
      tick();
    end
    wr_en = 1'b0; err = 1'b0;
    wait_quiet("rand_settle");

    // Reset in the middle of an offer.
    ctl_mode = 0;
    repeat (2) tick();
    write(16'h5555);
    for (int i = 0; i < 10 && !data_ready; i++) tick();
    chk("mid_present", 32'(data_ready), 1);
    n_reset = 1'b0;
    #1;
    chk("mid_rst_dr", 32'(data_ready), 0);
    chk("mid_rst_sample", 32'(sample), 0);
    chk("mid_rst_sc", 32'(sample_count), 0);
    chk("mid_rst_ec", 32'(err_count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    repeat (2) tick();
    n_reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_idle", 32'(data_ready), 0);
    end
    write(16'h6666);
    repeat (TIMEOUT + 4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sample_feeder.md
Name: sample_feeder

Overview:
- Initiator side of the data_ready/modwait sample handshake consumed by the FIR controller.
- Buffers incoming samples in a small FIFO.
- Presents one sample at a time on `sample` with `data_ready` asserted, and holds it until the controller acknowledges by raising `modwait`.
- Waits for `modwait` to fall before offering the next sample; tracks accepted samples, timeouts, and controller error events.

Parameters:
- DATA_W, 16, width of each sample word.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- TIMEOUT, 8, maximum cycles `data_ready` stays high without `modwait` rising; minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  asynchronous active-low reset.
- wr_en  in  1  push `wr_data` into the FIFO.
- wr_data  in  DATA_W  sample to enqueue.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- overrun  out  1  one-cycle pulse: `wr_en` while full, write dropped.
- modwait  in  1  controller busy/acknowledge.
- err  in  1  controller error flag.
- data_ready  out  1  sample valid to controller.
- sample  out  DATA_W  sample presented to controller.
- timeout  out  1  one-cycle pulse: presented sample dropped, no acknowledge.
- sample_count  out  8  accepted samples, wraps 255→0.
- err_count  out  8  rising edges of `err`, saturates at 255.

Behaviour:
- Reset (async, n_reset=0): state IDLE, FIFO empty (full=0, empty=1), and all of the following are 0: data_ready, sample, overrun, timeout, sample_count, err_count. Reset mid-handshake abandons the sample in flight.
- All outputs are registered except `full` and `empty`, which decode directly from the registered occupancy count.
- FIFO:
  - Write accepted when wr_en=1 and full=0 at the clock edge.
  - wr_en=1 with full=1: data discarded, overrun=1 for the next cycle.
  - Pop occurs only on the IDLE→PRESENT transition.
  - Push and pop on the same edge: both occur, occupancy unchanged.
  - A push while full is rejected even if a pop occurs on that same edge.
  - Pointers wrap modulo DEPTH.
- FSM states are IDLE, PRESENT and WAIT_DONE.
- IDLE:
  - data_ready=0.
  - If empty=0 and modwait=0: load the FIFO head into `sample`, pop, and go to PRESENT; clear the wait counter.
  - Otherwise stay in IDLE.
  - Latency: a write into an empty FIFO at edge N gives data_ready=1 after edge N+1.
- PRESENT:
  - data_ready=1; `sample` is stable for the entire state.
  - Wait counter increments each cycle.
  - If modwait=1: go to WAIT_DONE; data_ready falls on that edge; sample_count increments.
    - `sample` stays unchanged through WAIT_DONE, so the controller's load op captures a stable value.
  - Else if the wait counter equals TIMEOUT-1: go to IDLE, timeout=1 for one cycle, sample discarded.
  - data_ready must remain high across at least two rising edges, because the controller checks it in both its idle and store states; with TIMEOUT≥2 this is guaranteed.
- WAIT_DONE:
  - data_ready=0.
  - If modwait=0: go to IDLE. Otherwise stay.
  - No timeout applies in this state.
- err:
  - err_count increments when err=1 and the previous-cycle err was 0, in any state; it holds at 255.
  - err does not alter FSM flow: the controller recovers by itself on the next data_ready.
- modwait already high in IDLE (controller still busy): no new presentation until it drops.

Test Plan:
- Single sample: write 16'h1234 at cycle 0, model controller raises modwait 2 cycles after data_ready, holds it 8 cycles → data_ready=1 cycles 1–2, sample=16'h1234 through modwait high, sample_count=1, empty=1.
- Burst: write 4 samples (16'h0001–16'h0004) on consecutive cycles → full=1 after 4th; samples presented in order, each only after modwait falls; sample_count=4.
- Overrun: fill FIFO, then a 5th write of 16'hDEAD → overrun pulses 1 cycle, FIFO contents unchanged, 16'hDEAD never presented.
- Timeout: modwait tied 0, write 16'hAAAA then 16'hBBBB → data_ready high 8 cycles, timeout pulse, then 16'hBBBB presented; sample_count=0.
- Error count: pulse err 3 times (1 cycle each) plus hold err high 5 cycles once → err_count=4.
- Reset mid-PRESENT: assert n_reset=0 while data_ready=1 → data_ready, sample, sample_count, err_count = 0 immediately; FIFO empty; after release, no presentation until a new write.
